// File: rtl/lsosc_tick_timer.sv
// Low-speed oscillator consumer: powers the LSOSC up, synchronises CLKLF,
// counts its rising edges, divides them into periodic tick/irq events and
// flags a stalled oscillator.
module lsosc_tick_timer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PWRUP_EDGES = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             lf_pu,
  output logic             lf_en,
  input  logic             lf_clk,
  output logic             tick,
  output logic             irq,
  input  logic             irq_ack,
  output logic             running,
  output logic             fault,
  output logic [CNT_W-1:0] lf_count
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_PWRUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW_W = $clog2(PWRUP_EDGES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWRUP_EDGES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   lf_edge;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             tick_d;
  logic [CNT_W-1:0] period_m1;

  logic pu_en_q, running_q, fault_q, tick_q, irq_q;

  assign lf_edge   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign period_m1 = (period == '0) ? '0 : period - CNT_W'(1);

  // Synchronise lf_clk and keep the previous synchronised level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lf_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state, edge counting, divider and stall timeout
  // The timeout expires on the cycle that would complete TIMEOUT_CYC quiet
  // cycles; an edge in that cycle takes priority and restarts the count.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    to_d    = to_q;
    tick_d  = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      div_d   = '0;
      cnt_d   = '0;
      pw_d    = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_PWRUP;
          pw_d    = '0;
          to_d    = '0;
        end
        ST_PWRUP: begin
          if (lf_edge) begin
            to_d = '0;
            if (pw_q == PW_LAST) begin
              state_d = ST_RUN;
              pw_d    = '0;
              div_d   = '0;
              cnt_d   = '0;
            end else begin
              pw_d = pw_q + PW_W'(1);
            end
          end else if (to_q >= TO_LAST) begin
            state_d = ST_FAULT;
            to_d    = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_RUN: begin
          if (lf_edge) begin
            to_d  = '0;
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q >= period_m1) begin
              div_d  = '0;
              tick_d = 1'b1;
            end else begin
              div_d = div_q + CNT_W'(1);
            end
          end else if (to_q >= TO_LAST) begin
            state_d = ST_FAULT;
            to_d    = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      div_q   <= '0;
      cnt_q   <= '0;
      pw_q    <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      to_q    <= to_d;
    end
  end

  // Registered status and oscillator control outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      pu_en_q   <= 1'b0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pu_en_q   <= (state_d == ST_PWRUP) || (state_d == ST_RUN);
      running_q <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
      tick_q    <= tick_d;
    end
  end

  // Sticky interrupt: a tick sets it, ack clears it, set beats ack
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (tick_q) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign lf_pu    = pu_en_q;
  assign lf_en    = pu_en_q;
  assign running  = running_q;
  assign fault    = fault_q;
  assign tick     = tick_q;
  assign irq      = irq_q;
  assign lf_count = cnt_q;

endmodule

// File: tb/tb_lsosc_tick_timer.sv
// Bench for lsosc_tick_timer: oscillator stand-in, behavioural reference
// model compared every cycle, directed scenarios with literal expectations,
// then a randomized run.
module tb_lsosc_tick_timer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PWRUP   = 4;
  localparam int unsigned TIMEOUT = 4096;

  localparam int M_OFF = 0, M_PWRUP = 1, M_RUN = 2, M_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] period = 16'd3;
  logic             irq_ack = 1'b0;
  logic             lf_clk = 1'b0;
  logic             lf_pu, lf_en, tick, irq, running, fault;
  logic [CNT_W-1:0] lf_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  logic stall = 1'b0;
  bit   rand_half = 1'b0;
  int   half = 8;
  int   lf_div = 0;

  lsosc_tick_timer #(
    .SYNC_STAGES(2),
    .PWRUP_EDGES(PWRUP),
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .period(period),
    .lf_pu(lf_pu),
    .lf_en(lf_en),
    .lf_clk(lf_clk),
    .tick(tick),
    .irq(irq),
    .irq_ack(irq_ack),
    .running(running),
    .fault(fault),
    .lf_count(lf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator stand-in: runs only while powered and enabled, held low otherwise
  always @(negedge clk) begin
    if (!(lf_pu && lf_en) || stall) begin
      lf_clk = 1'b0;
      lf_div = 0;
    end else begin
      lf_div++;
      if (lf_div >= half) begin
        lf_clk = ~lf_clk;
        lf_div = 0;
        if (rand_half) half = $urandom_range(9, 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_mode = M_OFF;
  int               m_pw = 0, m_quiet = 0, m_since = 0;
  logic [CNT_W-1:0] m_lfc = '0;
  bit               m_tick = 0, m_irq = 0;
  bit               h1 = 0, h2 = 0, h3 = 0;   // lf_clk samples 1, 2, 3 cycles ago
  bit               prev_samp = 0;
  int               mcyc = 0;
  int               rise_c = -100;

  initial begin
    bit e, samp, pwr;
    int plim;
    forever begin
      @(posedge clk);
      mcyc++;
      samp = (lf_clk === 1'b1);
      if (rst) begin
        m_mode = M_OFF; m_pw = 0; m_quiet = 0; m_since = 0; m_lfc = '0;
        m_tick = 0; m_irq = 0; h1 = 0; h2 = 0; h3 = 0; prev_samp = 0;
      end else begin
        // A sample first seen high two cycles ago is the edge acted on now
        e = h2 && !h3;
        if (m_tick) m_irq = 1;
        else if (irq_ack) m_irq = 0;
        m_tick = 0;
        plim = (period == 0) ? 1 : int'(period);
        if (!enable) begin
          m_mode = M_OFF; m_pw = 0; m_quiet = 0; m_since = 0; m_lfc = '0;
        end else begin
          case (m_mode)
            M_OFF: begin m_mode = M_PWRUP; m_pw = 0; m_quiet = 0; end
            M_PWRUP, M_RUN: begin
              if (e) begin
                m_quiet = 0;
                if (m_mode == M_PWRUP) begin
                  m_pw++;
                  if (m_pw == PWRUP) begin
                    m_mode = M_RUN; m_pw = 0; m_lfc = '0; m_since = 0;
                  end
                end else begin
                  m_lfc++;
                  m_since++;
                  if (m_since >= plim) begin m_since = 0; m_tick = 1; end
                end
              end else begin
                m_quiet++;
                if (m_quiet >= TIMEOUT) m_mode = M_FAULT;
              end
            end
            default: ;
          endcase
        end
        if (samp && !prev_samp) rise_c = mcyc;
        prev_samp = samp;
        h3 = h2; h2 = h1; h1 = samp;
      end
      #1;
      pwr = (m_mode == M_PWRUP) || (m_mode == M_RUN);
      chk("tick", tick, m_tick);
      chk("irq", irq, m_irq);
      chk("running", running, m_mode == M_RUN);
      chk("fault", fault, m_mode == M_FAULT);
      chk("lf_pu", lf_pu, pwr);
      chk("lf_en", lf_en, pwr);
      chk("lf_count", lf_count, m_lfc);
      if (tick === 1'b1) chk("tick_latency", mcyc - rise_c, 2);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 running, 1 tick, 2 fault, other: lf_count change
  task automatic wait_ev(input string name, input int which, input int budget);
    logic [CNT_W-1:0] c0;
    bit hit;
    int waited;
    c0 = lf_count;
    hit = 0;
    waited = 0;
    while (!hit && waited < budget) begin
      step();
      waited++;
      case (which)
        0: hit = (running === 1'b1);
        1: hit = (tick === 1'b1);
        2: hit = (fault === 1'b1);
        default: hit = (lf_count !== c0);
      endcase
    end
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int t0, c;
    logic [CNT_W-1:0] c0;

    // Reset and idle
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("idle_outputs", {lf_pu, lf_en, tick, irq, running, fault}, 0);
    chk("idle_count", lf_count, 0);

    // Power-up, period 3
    enable = 1'b1;
    step();
    chk("pu_next_cycle", lf_pu, 1);
    chk("en_next_cycle", lf_en, 1);
    chk("not_running_yet", running, 0);
    wait_ev("reach_run", 0, 200);
    chk("count_at_run", lf_count, 0);
    wait_ev("tick1", 1, 200);
    chk("first_tick_count", lf_count, 3);
    t0 = cyc;
    wait_ev("tick2", 1, 100);
    chk("tick_interval_a", cyc - t0, 48);
    t0 = cyc;
    wait_ev("tick3", 1, 100);
    chk("tick_interval_b", cyc - t0, 48);
    chk("third_tick_count", lf_count, 9);
    step();
    chk("irq_set", irq, 1);

    // irq acknowledge behaviour
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_ack_clear", irq, 0);
    wait_ev("tick4", 1, 100);
    irq_ack = 1'b1;
    step();
    chk("irq_set_wins", irq, 1);
    step();
    chk("irq_ack_later", irq, 0);
    irq_ack = 1'b0;

    // Period change with divider at 5
    period = 16'd10;
    wait_ev("tick_p10", 1, 250);
    for (int i = 0; i < 5; i++) wait_ev("edge_p10", 3, 40);
    period = 16'd2;
    wait_ev("edge_lower", 3, 40);
    chk("tick_after_lower", tick, 1);
    wait_ev("edge_p2a", 3, 40);
    chk("p2_no_tick", tick, 0);
    wait_ev("edge_p2b", 3, 40);
    chk("p2_tick", tick, 1);
    period = 16'd0;
    wait_ev("edge_p0a", 3, 40);
    chk("p0_tick_a", tick, 1);
    wait_ev("edge_p0b", 3, 40);
    chk("p0_tick_b", tick, 1);

    // Stalled oscillator
    wait_ev("edge_before_stall", 3, 40);
    c = cyc;
    stall = 1'b1;
    wait_ev("stall_fault", 2, 5000);
    chk("stall_timeout", cyc - c, TIMEOUT);
    chk("fault_pu", lf_pu, 0);
    chk("fault_en", lf_en, 0);
    chk("fault_not_running", running, 0);
    enable = 1'b0;
    step();
    chk("off_clears_fault", fault, 0);
    stall = 1'b0;
    enable = 1'b1;
    wait_ev("rerun", 0, 200);

    // Disable keeps irq, reset clears everything
    period = 16'd1;
    wait_ev("tick_p1", 1, 100);
    step();
    chk("irq_before_disable", irq, 1);
    enable = 1'b0;
    step();
    chk("disable_running", running, 0);
    chk("disable_count", lf_count, 0);
    chk("irq_survives_disable", irq, 1);
    enable = 1'b1;
    wait_ev("run_again", 0, 200);
    wait_ev("edge_before_rst", 3, 40);
    c0 = lf_count;
    chk("count_nonzero", c0 != 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_outputs", {lf_pu, lf_en, tick, irq, running, fault}, 0);
    chk("rst_count", lf_count, 0);

    // Randomized run with jittered oscillator
    rand_half = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      irq_ack = ($urandom_range(3, 0) == 0);
      if ($urandom_range(29, 0) == 0) period = CNT_W'($urandom_range(5, 0));
      enable = ($urandom_range(199, 0) != 0);
      rst = ($urandom_range(299, 0) == 0);
      step();
    end
    rst = 1'b0;
    irq_ack = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
